// File: rtl/uart_rx.sv
// uart_rx - 8N1 UART receiver with 16x oversampling.
//   The RX line passes through a 2-FF synchroniser. Each bit is sampled on
//   oversample ticks 7, 8 and 9, and the bit value is the majority of the
//   three. A start bit that reads high at mid-bit is treated as a glitch and
//   dropped. A low stop bit raises a framing error, and the receiver then
//   waits for the line to return high before it looks for another start.
// Ports:
//   i_SysClock  system clock, rising edge
//   i_ResetN    asynchronous active-low reset
//   i_RxSerial  asynchronous serial input, idle high
//   o_RxByte    last correctly framed byte (held between frames)
//   o_RxValid   one-cycle pulse when o_RxByte updates
//   o_FrameErr  one-cycle pulse on a bad stop bit
//   o_RxBusy    high whenever the receiver is not idle
module uart_rx #(
   parameter int SYS_CLOCK     = 50000000,
   parameter int UART_BAUDRATE = 115200
) (
   input  logic       i_SysClock,
   input  logic       i_ResetN,
   input  logic       i_RxSerial,
   output logic [7:0] o_RxByte,
   output logic       o_RxValid,
   output logic       o_FrameErr,
   output logic       o_RxBusy
);
   // Clocks per oversample tick, rounded to nearest.
   localparam int OS_DIV = int'(((longint'(SYS_CLOCK) * 10 / (longint'(UART_BAUDRATE) * 16)) + 5) / 10);
   localparam int PW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(OS_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t        state, state_nxt;
   logic          rx_meta, rx_s;
   logic [PW-1:0] presc;
   logic [3:0]    tick_cnt;
   logic          tick, at_t9, at_t15;
   logic          smp7, smp8, maj;
   logic [7:0]    shift_reg;
   logic [2:0]    bit_idx;
   logic          shift_en, valid_nxt, ferr_nxt;

   // Synchroniser resets to the idle level so reset release never looks like a start.
   always_ff @(posedge i_SysClock or negedge i_ResetN) begin
      if (!i_ResetN) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_RxSerial;
         rx_s    <= rx_meta;
      end
   end

   // The prescaler only runs inside a frame, so its phase is set by the start edge.
   assign tick   = (state != S_IDLE) && (state != S_BREAK) && (presc == PRESC_MAX);
   assign at_t9  = tick && (tick_cnt == 4'd9);
   assign at_t15 = tick && (tick_cnt == 4'd15);
   // Tick-9 sample is the live rx_s; ticks 7 and 8 come from the capture regs.
   assign maj    = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);

   always_ff @(posedge i_SysClock or negedge i_ResetN) begin
      if (!i_ResetN) begin
         presc     <= '0;
         tick_cnt  <= '0;
         smp7      <= 1'b1;
         smp8      <= 1'b1;
         shift_reg <= '0;
         bit_idx   <= '0;
      end else begin
         if (state == S_IDLE || state == S_BREAK) begin
            presc    <= '0;
            tick_cnt <= '0;
         end else if (tick) begin
            presc    <= '0;
            tick_cnt <= tick_cnt + 4'd1;
         end else begin
            presc    <= presc + 1'b1;
         end
         if (tick && tick_cnt == 4'd7) smp7 <= rx_s;
         if (tick && tick_cnt == 4'd8) smp8 <= rx_s;
         // LSB arrives first, so shift right and insert at the top.
         if (shift_en) shift_reg <= {maj, shift_reg[7:1]};
         if (state == S_START)
            bit_idx <= '0;
         else if (state == S_DATA && at_t15)
            bit_idx <= bit_idx + 3'd1;
      end
   end

   always_ff @(posedge i_SysClock or negedge i_ResetN) begin
      if (!i_ResetN) state <= S_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      case (state)
         S_IDLE:  if (!rx_s) state_nxt = S_START;
         S_START: begin
            if (at_t9 && maj) state_nxt = S_IDLE;   // false start
            else if (at_t15)  state_nxt = S_DATA;
         end
         S_DATA: begin
            if (at_t9) shift_en = 1'b1;
            if (at_t15 && bit_idx == 3'd7) state_nxt = S_STOP;
         end
         // Leave at mid-stop-bit to keep half a bit of slack for the next start.
         S_STOP: begin
            if (at_t9) begin
               if (maj) begin
                  valid_nxt = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = S_BREAK;
               end
            end
         end
         // A held-low line must go high before another start is accepted.
         S_BREAK: if (rx_s) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_SysClock or negedge i_ResetN) begin
      if (!i_ResetN) begin
         o_RxByte   <= '0;
         o_RxValid  <= 1'b0;
         o_FrameErr <= 1'b0;
      end else begin
         o_RxValid  <= valid_nxt;
         o_FrameErr <= ferr_nxt;
         if (valid_nxt) o_RxByte <= shift_reg;
      end
   end

   assign o_RxBusy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - randomized and directed bench for uart_rx.
//   Frames are produced clock by clock from a bit-level description of each
//   frame: start bit, eight data bits LSB first, then the stop bit. Optional
//   baud skew and a single inverted glitch can be added. The reference model
//   is a queue of bytes that should arrive plus a count of framing errors
//   that should be seen.
module tb_uart_rx;
   localparam int SYS_CLOCK = 1600000;
   localparam int BAUD      = 10000;
   localparam int BITC      = 160;

   logic       i_SysClock = 1'b0;
   logic       i_ResetN   = 1'b0;
   logic       i_RxSerial = 1'b1;
   logic [7:0] o_RxByte;
   logic       o_RxValid, o_FrameErr, o_RxBusy;

   uart_rx #(.SYS_CLOCK(SYS_CLOCK), .UART_BAUDRATE(BAUD)) dut (
      .i_SysClock (i_SysClock),
      .i_ResetN   (i_ResetN),
      .i_RxSerial (i_RxSerial),
      .o_RxByte   (o_RxByte),
      .o_RxValid  (o_RxValid),
      .o_FrameErr (o_FrameErr),
      .o_RxBusy   (o_RxBusy)
   );

   always #5 i_SysClock = ~i_SysClock;

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   always @(posedge i_SysClock) cyc++;

   logic [7:0] got_q[$], exp_q[$];
   int         vcyc_q[$];
   int         fe_cnt = 0, exp_fe = 0, both_cnt = 0;

   always @(negedge i_SysClock) begin
      if (o_RxValid) begin
         got_q.push_back(o_RxByte);
         vcyc_q.push_back(cyc);
      end
      if (o_FrameErr) fe_cnt++;
      if (o_RxValid && o_FrameErr) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one frame; gbit selects the frame bit (0=start, 9=stop) to glitch.
   task automatic send(input logic [7:0] d, input int bclk, input logic stp,
                       input int gbit, input int glo);
      logic [9:0] fr;
      logic       v;
      fr = {stp, d, 1'b0};
      for (int b = 0; b < 10; b++)
         for (int c = 0; c < bclk; c++) begin
            @(negedge i_SysClock);
            v = fr[b];
            if (b == gbit && c >= glo && c < glo + 10) v = ~v;
            i_RxSerial = v;
         end
   endtask

   task automatic line(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge i_SysClock);
         i_RxSerial = v;
      end
   endtask

   task automatic drain(input string tag);
      chk({tag, "_cnt"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk({tag, "_byte"}, got_q[i], exp_q[i]);
      chk({tag, "_ferr"}, fe_cnt, exp_fe);
      got_q.delete();
      exp_q.delete();
      vcyc_q.delete();
   endtask

   initial begin
      int         bc, gap, gb;
      logic [7:0] d;
      int         skew[3];

      repeat (5) @(negedge i_SysClock);
      chk("rst_byte",  o_RxByte,   8'h00);
      chk("rst_valid", o_RxValid,  1'b0);
      chk("rst_ferr",  o_FrameErr, 1'b0);
      chk("rst_busy",  o_RxBusy,   1'b0);
      i_ResetN = 1'b1;
      line(1'b1, 20);

      // 1: single nominal frame, busy window
      exp_q.push_back(8'hA5);
      fork
         send(8'hA5, BITC, 1'b1, -1, 0);
         begin
            repeat (2) @(negedge i_SysClock);
            chk("t1_busy_pre", o_RxBusy, 1'b0);
            repeat (4) @(negedge i_SysClock);
            chk("t1_busy_on", o_RxBusy, 1'b1);
            repeat (800) @(negedge i_SysClock);
            chk("t1_busy_mid", o_RxBusy, 1'b1);
         end
      join
      line(1'b1, 40);
      chk("t1_busy_off", o_RxBusy, 1'b0);
      chk("t1_out", o_RxByte, 8'hA5);
      drain("t1");

      // 2: back-to-back frames, no idle gap
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send(8'h00, BITC, 1'b1, -1, 0);
      send(8'hFF, BITC, 1'b1, -1, 0);
      line(1'b1, 40);
      chk("t2_gap", (vcyc_q.size() >= 2) ? vcyc_q[1] - vcyc_q[0] : 0, 32'd1600);
      drain("t2");

      // 3: 40-clock false start, then a good frame
      line(1'b0, 40);
      chk("t3_busy_on", o_RxBusy, 1'b1);
      line(1'b1, 120);
      chk("t3_busy_off", o_RxBusy, 1'b0);
      drain("t3a");
      exp_q.push_back(8'h3C);
      send(8'h3C, BITC, 1'b1, -1, 0);
      line(1'b1, 40);
      drain("t3b");

      // 4: bad stop bit followed by a held-low line
      exp_fe++;
      send(8'h55, BITC, 1'b0, -1, 0);
      line(1'b0, 240);
      chk("t4_busy_break", o_RxBusy, 1'b1);
      line(1'b0, 240);
      chk("t4_byte_hold", o_RxByte, 8'h3C);
      line(1'b1, 20);
      chk("t4_busy_off", o_RxBusy, 1'b0);
      drain("t4a");
      exp_q.push_back(8'h3C);
      send(8'h3C, BITC, 1'b1, -1, 0);
      line(1'b1, 40);
      drain("t4b");

      // 5: asynchronous reset in the middle of data bit 4
      fork
         send(8'hF0, BITC, 1'b1, -1, 0);
         begin
            repeat (881) @(negedge i_SysClock);
            #2 i_ResetN = 1'b0;
            #2;
            chk("t5_busy",  o_RxBusy,   1'b0);
            chk("t5_valid", o_RxValid,  1'b0);
            chk("t5_ferr",  o_FrameErr, 1'b0);
            chk("t5_byte",  o_RxByte,   8'h00);
         end
      join
      line(1'b1, 10);
      i_ResetN = 1'b1;
      line(1'b1, 20);
      drain("t5a");
      exp_q.push_back(8'h81);
      send(8'h81, BITC, 1'b1, -1, 0);
      line(1'b1, 40);
      drain("t5b");

      // 6: baud skew with a 10-clock glitch in data bit 2 around its mid-bit samples
      skew[0] = BITC;
      skew[1] = 155;
      skew[2] = 165;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(8'hC3);
         send(8'hC3, skew[k], 1'b1, 3, skew[k] * 85 / BITC);
         line(1'b1, 40);
         drain($sformatf("t6_%0d", skew[k]));
      end

      // Random frames: random byte, skew, idle gap and optional single glitch
      for (int n = 0; n < 10; n++) begin
         d   = 8'($urandom);
         bc  = $urandom_range(164, 156);
         gap = $urandom_range(40, 0);
         gb  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(8, 1)) : -1;
         exp_q.push_back(d);
         send(d, bc, 1'b1, gb, bc * 85 / BITC);
         line(1'b1, gap);
      end
      line(1'b1, 40);
      drain("rnd");

      chk("valid_ferr_overlap", both_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
